// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: receiver push, consumer read and status signals of the UART RX byte FIFO.
interface uart_rx_fifo_if #(parameter int DEPTH_LOG2 = 4);
    logic [7:0]          i_rx_data;
    logic                i_rx_done;
    logic [7:0]          o_data;
    logic                o_valid;
    logic                i_ready;
    logic [DEPTH_LOG2:0] o_count;
    logic                o_full;
    logic                o_overflow;
    logic                i_clr_overflow;
    logic                o_timeout;
    modport master (
        output i_rx_data, i_rx_done, i_ready, i_clr_overflow,
        input  o_data, o_valid, o_count, o_full, o_overflow, o_timeout
    );
    modport slave (
        input  i_rx_data, i_rx_done, i_ready, i_clr_overflow,
        output o_data, o_valid, o_count, o_full, o_overflow, o_timeout
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through byte FIFO behind the UART receiver with sticky overflow.
// Define UART_RX_FIFO_TIMEOUT_EN to add the one-shot idle-line timeout pulse.
module uart_rx_fifo #(
    parameter int DEPTH_LOG2   = 4,
    parameter int BAUD_RATE    = 115200,
    parameter int CLK_HZ       = 25000000,
    parameter int TIMEOUT_BITS = 40
) (
    input logic           i_Clk,
    input logic           i_reset,
    uart_rx_fifo_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_ptr, wr_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  do_push, do_pop;
    assign bus.o_valid = count != '0;
    assign bus.o_full  = count == (DEPTH_LOG2+1)'(DEPTH);
    assign bus.o_count = count;
    assign bus.o_data  = mem[rd_ptr];
    assign do_pop      = bus.o_valid & bus.i_ready;
    // a pop in the same cycle frees the slot a full FIFO needs
    assign do_push     = bus.i_rx_done & (!bus.o_full | do_pop);
    always_ff @(posedge i_Clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            count          <= '0;
            bus.o_overflow <= 1'b0;
        end else begin
            if (do_push) mem[wr_ptr] <= bus.i_rx_data;
            wr_ptr         <= do_push ? wr_ptr + DEPTH_LOG2'(1) : wr_ptr;
            rd_ptr         <= do_pop ? rd_ptr + DEPTH_LOG2'(1) : rd_ptr;
            count          <= (do_push & !do_pop) ? count + (DEPTH_LOG2+1)'(1) :
                              (!do_push & do_pop) ? count - (DEPTH_LOG2+1)'(1) : count;
            bus.o_overflow <= (bus.i_rx_done & !do_push) ? 1'b1 :
                              bus.i_clr_overflow ? 1'b0 : bus.o_overflow;
        end
    end
`ifdef UART_RX_FIFO_TIMEOUT_EN
    localparam logic [31:0] LIMIT = 32'(TIMEOUT_BITS * (CLK_HZ / BAUD_RATE) - 1);
    logic [31:0] idle_cnt;
    logic        rearm;
    assign rearm = do_push | do_pop | (count == '0);
    // counter parks at LIMIT so the pulse fires once per idle stretch
    always_ff @(posedge i_Clk or posedge i_reset) begin
        if (i_reset) begin
            idle_cnt      <= '0;
            bus.o_timeout <= 1'b0;
        end else begin
            idle_cnt      <= rearm ? '0 : (idle_cnt == LIMIT) ? idle_cnt : idle_cnt + 32'd1;
            bus.o_timeout <= !rearm && idle_cnt == LIMIT - 32'd1;
        end
    end
`else
    assign bus.o_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed checks of push/pop, overflow, wrap, async reset and idle timeout.
module tb_uart_rx_fifo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    uart_rx_fifo_if #(.DEPTH_LOG2(2)) bus ();
    uart_rx_fifo #(
        .DEPTH_LOG2(2), .BAUD_RATE(100), .CLK_HZ(1000), .TIMEOUT_BITS(4)
    ) dut (
        .i_Clk(clk), .i_reset(rst), .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic push(input logic [7:0] b);
        bus.i_rx_data = b;
        bus.i_rx_done = 1'b1;
        step();
        bus.i_rx_done = 1'b0;
    endtask
    task automatic test_reset();
        bus.i_rx_data = 8'h00;
        bus.i_rx_done = 1'b0;
        bus.i_ready = 1'b0;
        bus.i_clr_overflow = 1'b0;
        rst = 1'b1;
        step();
        step();
        checks++;
        if ({bus.o_valid, bus.o_count, bus.o_full, bus.o_overflow, bus.o_timeout, bus.o_data} !== {1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL reset: valid=%b count=%0d full=%b ovf=%b to=%b data=%h, need 0 0 0 0 0 00",
                     bus.o_valid, bus.o_count, bus.o_full, bus.o_overflow, bus.o_timeout, bus.o_data);
        end
        rst = 1'b0;
        step();
    endtask
    task automatic test_single();
        push(8'hA5);
        checks++;
        if ({bus.o_valid, bus.o_data, bus.o_count} !== {1'b1, 8'hA5, 3'd1}) begin
            errors++;
            $display("FAIL single_push: valid=%b data=%h count=%0d, need 1 a5 1", bus.o_valid, bus.o_data, bus.o_count);
        end
        bus.i_ready = 1'b1;
        step();
        bus.i_ready = 1'b0;
        checks++;
        if ({bus.o_valid, bus.o_count} !== {1'b0, 3'd0}) begin
            errors++;
            $display("FAIL single_pop: valid=%b count=%0d, need 0 0", bus.o_valid, bus.o_count);
        end
        bus.i_ready = 1'b1;
        step();
        bus.i_ready = 1'b0;
        checks++;
        if ({bus.o_valid, bus.o_count} !== {1'b0, 3'd0}) begin
            errors++;
            $display("FAIL empty_pop: valid=%b count=%0d, need 0 0", bus.o_valid, bus.o_count);
        end
    endtask
    task automatic drain(input string name, input logic [7:0] exp [4]);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({bus.o_valid, bus.o_data} !== {1'b1, exp[i]}) begin
                errors++;
                $display("FAIL %s[%0d]: valid=%b data=%h, need 1 %h", name, i, bus.o_valid, bus.o_data, exp[i]);
            end
            bus.i_ready = 1'b1;
            step();
            bus.i_ready = 1'b0;
        end
        checks++;
        if ({bus.o_valid, bus.o_count} !== {1'b0, 3'd0}) begin
            errors++;
            $display("FAIL %s_empty: valid=%b count=%0d, need 0 0", name, bus.o_valid, bus.o_count);
        end
    endtask
    task automatic test_overflow();
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        checks++;
        if ({bus.o_full, bus.o_count, bus.o_overflow} !== {1'b1, 3'd4, 1'b0}) begin
            errors++;
            $display("FAIL fill: full=%b count=%0d ovf=%b, need 1 4 0", bus.o_full, bus.o_count, bus.o_overflow);
        end
        push(8'h55);
        checks++;
        if ({bus.o_overflow, bus.o_count, bus.o_data} !== {1'b1, 3'd4, 8'h11}) begin
            errors++;
            $display("FAIL drop: ovf=%b count=%0d data=%h, need 1 4 11", bus.o_overflow, bus.o_count, bus.o_data);
        end
        drain("ovf_drain", '{8'h11, 8'h22, 8'h33, 8'h44});
        bus.i_clr_overflow = 1'b1;
        step();
        bus.i_clr_overflow = 1'b0;
        checks++;
        if (bus.o_overflow !== 1'b0) begin
            errors++;
            $display("FAIL clr_overflow: ovf=%b, need 0", bus.o_overflow);
        end
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        bus.i_clr_overflow = 1'b1;
        push(8'h05);
        bus.i_clr_overflow = 1'b0;
        checks++;
        if (bus.o_overflow !== 1'b1) begin
            errors++;
            $display("FAIL set_wins: ovf=%b, need 1", bus.o_overflow);
        end
        drain("setwin_drain", '{8'h01, 8'h02, 8'h03, 8'h04});
        bus.i_clr_overflow = 1'b1;
        step();
        bus.i_clr_overflow = 1'b0;
    endtask
    task automatic test_push_pop_full();
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        bus.i_ready = 1'b1;
        push(8'h66);
        bus.i_ready = 1'b0;
        checks++;
        if ({bus.o_overflow, bus.o_count, bus.o_full, bus.o_data} !== {1'b0, 3'd4, 1'b1, 8'h22}) begin
            errors++;
            $display("FAIL full_push_pop: ovf=%b count=%0d full=%b data=%h, need 0 4 1 22",
                     bus.o_overflow, bus.o_count, bus.o_full, bus.o_data);
        end
        drain("pp_drain", '{8'h22, 8'h33, 8'h44, 8'h66});
    endtask
    task automatic test_wrap();
        for (int i = 0; i < 6; i++) begin
            push(8'(i));
            checks++;
            if ({bus.o_valid, bus.o_data, bus.o_count} !== {1'b1, 8'(i), 3'd1}) begin
                errors++;
                $display("FAIL wrap[%0d]: valid=%b data=%h count=%0d, need 1 %h 1", i, bus.o_valid, bus.o_data, bus.o_count, 8'(i));
            end
            bus.i_ready = 1'b1;
            step();
            bus.i_ready = 1'b0;
        end
        checks++;
        if (bus.o_count !== 3'd0) begin
            errors++;
            $display("FAIL wrap_end: count=%0d, need 0", bus.o_count);
        end
    endtask
    task automatic test_timeout();
        int pulses = 0;
        int first = -1;
`ifdef UART_RX_FIFO_TIMEOUT_EN
        int exp_pulses = 1;
        int exp_first = 39;
`else
        int exp_pulses = 0;
        int exp_first = -1;
`endif
        push(8'h99);
        for (int k = 1; k <= 139; k++) begin
            step();
            if (bus.o_timeout === 1'b1) begin
                pulses++;
                if (first < 0) first = k;
            end
        end
        checks++;
        if (pulses != exp_pulses || first != exp_first) begin
            errors++;
            $display("FAIL timeout_idle: pulses=%0d first=%0d, need %0d %0d", pulses, first, exp_pulses, exp_first);
        end
        bus.i_ready = 1'b1;
        step();
        bus.i_ready = 1'b0;
        pulses = 0;
        for (int k = 0; k < 100; k++) begin
            if (bus.o_timeout === 1'b1) pulses++;
            step();
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL timeout_empty: pulses=%0d, need 0", pulses);
        end
    endtask
    task automatic test_mid_reset();
        push(8'h31); push(8'h32); push(8'h33); push(8'h34); push(8'h35);
        checks++;
        if ({bus.o_count, bus.o_overflow} !== {3'd4, 1'b1}) begin
            errors++;
            $display("FAIL pre_reset: count=%0d ovf=%b, need 4 1", bus.o_count, bus.o_overflow);
        end
        bus.i_rx_data = 8'h36;
        bus.i_rx_done = 1'b1;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.o_valid, bus.o_count, bus.o_overflow, bus.o_full} !== {1'b0, 3'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: valid=%b count=%0d ovf=%b full=%b, need 0 0 0 0",
                     bus.o_valid, bus.o_count, bus.o_overflow, bus.o_full);
        end
        bus.i_rx_done = 1'b0;
        step();
        rst = 1'b0;
        step();
        push(8'h7E);
        checks++;
        if ({bus.o_valid, bus.o_data, bus.o_count} !== {1'b1, 8'h7E, 3'd1}) begin
            errors++;
            $display("FAIL post_reset: valid=%b data=%h count=%0d, need 1 7e 1", bus.o_valid, bus.o_data, bus.o_count);
        end
    endtask
    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_push_pop_full();
        test_wrap();
        test_timeout();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
